order_fetch_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the 023A core's instruction fetch port (order_address / order_bus / order_read_cplt) and the external instruction memory bus. Hits complete in the same cycle the address is presented. Misses fetch a whole line from memory over a req/ack handshake, writing the line into the cache one word per beat. A flush input invalidates all lines, for use after code is loaded or modified.

---
 rtl/order_fetch_cache.sv | 173 +++++++++++++++++
 tb/tb_order_fetch_cache.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/order_fetch_cache.sv
// order_fetch_cache: direct-mapped, read-only instruction cache for the 023A fetch port.
//
// Hits return the instruction word combinationally from order_address. A miss
// fetches the whole line from memory over a registered req/ack bus, one word per
// beat, starting at offset 0. flush invalidates every line; a fill in flight still
// runs to completion but leaves its line invalid.
//
// Optional build macro: ORDER_CACHE_STATS_EN adds 32-bit hit/miss counters.
// Without it hit_count/miss_count are tied to 0.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   order_address    core fetch address (bits [1:0] ignored)
//   order_bus        instruction word, 0 unless order_read_cplt
//   order_read_cplt  order_bus valid for the current order_address
//   flush            single-cycle pulse, invalidates all lines
//   mem_req/mem_addr registered memory read request and word address
//   mem_rdata        memory read data, valid with mem_ack
//   mem_ack          beat accept; ignored while mem_req=0
//   hit_count        hit counter
//   miss_count       miss counter
module order_fetch_cache #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LINES      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] order_address,
  output logic [31:0] order_bus,
  output logic        order_read_cplt,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned OB = $clog2(LINE_WORDS);
  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TW = 32 - 2 - OB - IB;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  logic [OB-1:0] offset;
  logic [IB-1:0] index;
  logic [TW-1:0] tag;
  logic          unused_addr_bits;

  assign offset           = order_address[2 +: OB];
  assign index            = order_address[2+OB +: IB];
  assign tag              = order_address[31 -: TW];
  assign unused_addr_bits = ^order_address[1:0];

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [OB-1:0]     beat_q, beat_d;
  logic [IB-1:0]     fill_index_q, fill_index_d;
  logic [TW-1:0]     fill_tag_q, fill_tag_d;
  // Set by a flush seen during FILL so the completed line is not marked valid.
  logic              kill_q, kill_d;

  logic [31:0]   data_q [LINES][LINE_WORDS];
  logic [TW-1:0] tag_q  [LINES];

  logic hit, beat_ack, last_beat;

  assign hit       = (state_q == StIdle) && valid_q[index] && (tag_q[index] == tag);
  assign beat_ack  = (state_q == StFill) && mem_req_q && mem_ack;
  assign last_beat = (beat_q == OB'(LINE_WORDS - 1));

  assign order_read_cplt = hit;
  assign order_bus       = hit ? data_q[index][offset] : 32'd0;
  assign mem_req         = mem_req_q;
  assign mem_addr        = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = flush ? '0 : valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    beat_d       = beat_q;
    fill_index_d = fill_index_q;
    fill_tag_d   = fill_tag_q;
    kill_d       = kill_q;
    unique case (state_q)
      StIdle: begin
        if (!hit) begin
          state_d      = StFill;
          mem_req_d    = 1'b1;
          mem_addr_d   = {order_address[31:2+OB], {(OB + 2){1'b0}}};
          fill_index_d = index;
          fill_tag_d   = tag;
          beat_d       = '0;
          kill_d       = 1'b0;
        end
      end
      StFill: begin
        if (flush) kill_d = 1'b1;
        if (beat_ack) begin
          if (last_beat) begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
            beat_d    = '0;
            // A flush on this same edge also wins over the fill.
            if (!(kill_q || flush)) valid_d[fill_index_q] = 1'b1;
          end else begin
            beat_d     = beat_q + 1'b1;
            mem_addr_d = mem_addr_q + 32'd4;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      beat_q       <= '0;
      fill_index_q <= '0;
      fill_tag_q   <= '0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      beat_q       <= beat_d;
      fill_index_q <= fill_index_d;
      fill_tag_q   <= fill_tag_d;
      kill_q       <= kill_d;
    end
  end

  // Storage arrays are not reset; valid_q guards every read.
  always_ff @(posedge clk) begin
    if (beat_ack) begin
      data_q[fill_index_q][beat_q] <= mem_rdata;
      if (last_beat) tag_q[fill_index_q] <= fill_tag_q;
    end
  end

`ifdef ORDER_CACHE_STATS_EN
  logic        miss_start;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign miss_start = (state_q == StIdle) && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (hit)        hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_order_fetch_cache.sv
module tb_order_fetch_cache;

  logic        clk;
  logic        rst_n;
  logic [31:0] order_address;
  logic [31:0] order_bus;
  logic        order_read_cplt;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;

  order_fetch_cache #(
    .LINE_WORDS(4),
    .LINES     (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .order_address  (order_address),
    .order_bus      (order_bus),
    .order_read_cplt(order_read_cplt),
    .flush          (flush),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic        cplt;
    logic [31:0] bus;
  } vec_t;

  vec_t vecs [5];

  // Memory contents: 0x11..0x44 for the 0x100 line, a fixed pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'h11 * ((a - 32'h100) / 4 + 1);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the edge that raised mem_req; services all four beats.
  task automatic fill_line(input logic [31:0] base, input int wait_beat, input int waits,
                           input int flush_beat);
    for (int k = 0; k < 4; k++) begin
      if (k == wait_beat) begin
        for (int w = 0; w < waits; w++) begin
          mem_ack = 1'b0;
          #1;
          chk("wait_req", 32'(mem_req), 32'd1);
          chk("wait_addr", mem_addr, base + 32'(4 * k));
          tick();
        end
      end
      mem_ack   = 1'b1;
      mem_rdata = mem_word(base + 32'(4 * k));
      flush     = (k == flush_beat);
      #1;
      chk("fill_req", 32'(mem_req), 32'd1);
      chk("fill_addr", mem_addr, base + 32'(4 * k));
      chk("fill_cplt", 32'(order_read_cplt), 32'd0);
      tick();
      mem_ack = 1'b0;
      flush   = 1'b0;
    end
    #1;
    chk("fill_done_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    vecs[0] = '{addr: 32'h108, cplt: 1'b1, bus: 32'h33};
    vecs[1] = '{addr: 32'h100, cplt: 1'b1, bus: 32'h11};
    vecs[2] = '{addr: 32'h10E, cplt: 1'b1, bus: 32'h44};
    vecs[3] = '{addr: 32'h105, cplt: 1'b1, bus: 32'h22};
    vecs[4] = '{addr: 32'h104, cplt: 1'b1, bus: 32'h22};

    rst_n         = 1'b0;
    order_address = 32'h100;
    flush         = 1'b0;
    mem_ack       = 1'b0;
    mem_rdata     = 32'd0;
    repeat (3) tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_cplt", 32'(order_read_cplt), 32'd0);
    chk("rst_bus", order_bus, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);

    // Cold miss then zero-wait fill.
    rst_n = 1'b1;
    #1;
    chk("cold_cplt", 32'(order_read_cplt), 32'd0);
    chk("cold_bus", order_bus, 32'd0);
    tick();
    chk("cold_req", 32'(mem_req), 32'd1);
    chk("cold_addr", mem_addr, 32'h100);
    fill_line(32'h100, -1, 0, -1);

    // Five hit cycles from the table.
    for (int i = 0; i < 5; i++) begin
      order_address = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_cplt", i), 32'(order_read_cplt), 32'(vecs[i].cplt));
      chk($sformatf("vec%0d_bus", i), order_bus, vecs[i].bus);
      tick();
    end

    // Conflict miss on same index, with wait states on beat 1.
    order_address = 32'h200;
    #1;
    chk("conf_cplt", 32'(order_read_cplt), 32'd0);
    tick();
`ifdef ORDER_CACHE_STATS_EN
    chk("stat_misses", miss_count, 32'd2);
    chk("stat_hits", hit_count, 32'd5);
`else
    chk("stat_misses", miss_count, 32'd0);
    chk("stat_hits", hit_count, 32'd0);
`endif
    chk("conf_req", 32'(mem_req), 32'd1);
    chk("conf_addr", mem_addr, 32'h200);
    fill_line(32'h200, 1, 3, -1);
    order_address = 32'h204;
    #1;
    chk("conf_hit_cplt", 32'(order_read_cplt), 32'd1);
    chk("conf_hit_bus", order_bus, 32'hC0DE_0204);
    order_address = 32'h100;
    #1;
    chk("evicted_cplt", 32'(order_read_cplt), 32'd0);
    tick();
    chk("refill_addr", mem_addr, 32'h100);

    // Flush at beat 2: line ends invalid.
    fill_line(32'h100, -1, 0, 2);
    chk("flush_mid_cplt", 32'(order_read_cplt), 32'd0);
    tick();
    // Flush coincident with the last ack.
    fill_line(32'h100, -1, 0, 3);
    chk("flush_last_cplt", 32'(order_read_cplt), 32'd0);
    tick();
    fill_line(32'h100, -1, 0, -1);
    order_address = 32'h10C;
    #1;
    chk("refill_cplt", 32'(order_read_cplt), 32'd1);
    chk("refill_bus", order_bus, 32'h44);

    // Flush during an IDLE hit; a stray ack with mem_req=0 must be ignored.
    order_address = 32'h104;
    flush         = 1'b1;
    mem_ack       = 1'b1;
    mem_rdata     = 32'hBAD;
    #1;
    chk("flush_hit_cplt", 32'(order_read_cplt), 32'd1);
    chk("flush_hit_bus", order_bus, 32'h22);
    tick();
    flush = 1'b0;
    #1;
    chk("after_flush_cplt", 32'(order_read_cplt), 32'd0);
    tick();
    chk("after_flush_addr", mem_addr, 32'h100);
    fill_line(32'h100, -1, 0, -1);
    order_address = 32'h100;
    #1;
    chk("stray_ack_bus", order_bus, 32'h11);

    // Line at the top of the address space.
    order_address = 32'hFFFF_FFF8;
    #1;
    chk("wrap_miss", 32'(order_read_cplt), 32'd0);
    tick();
    chk("wrap_base", mem_addr, 32'hFFFF_FFF0);
    fill_line(32'hFFFF_FFF0, -1, 0, -1);
    chk("wrap_cplt", 32'(order_read_cplt), 32'd1);
    chk("wrap_bus", order_bus, mem_word(32'hFFFF_FFF8));

    // Reset in the middle of a fill.
    order_address = 32'h300;
    #1;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234;
    tick();
    mem_ack = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_cplt", 32'(order_read_cplt), 32'd0);
    chk("midrst_hits", hit_count, 32'd0);
    tick();
    rst_n         = 1'b1;
    order_address = 32'h10C;
    #1;
    chk("postrst_cplt", 32'(order_read_cplt), 32'd0);
    chk("postrst_bus", order_bus, 32'd0);
    tick();
    chk("postrst_req", 32'(mem_req), 32'd1);
    chk("postrst_addr", mem_addr, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
